// File: rtl/qpn_sched_pkg.sv
// Shared definitions for the RoCE per-QP transmit scheduler.
// QP index i maps to QPn QP_BASE+i, matching the IMC mapping IMC_0->2, IMC_1->3, IMC_2->4.
package qpn_sched_pkg;
    localparam int NUM_QP_DEF  = 3;
    localparam int QP_BASE_DEF = 2;
    localparam int PSN_W_DEF   = 24;
    localparam int QPN_W       = 4;

    typedef enum logic {IDLE, ISSUE} sched_state_e;

    typedef struct packed {
        logic             vld;
        logic [QPN_W-1:0] idx;
    } qp_map_t;

    function automatic qp_map_t qpn_to_idx(input logic [QPN_W-1:0] qpn,
                                           input int base = QP_BASE_DEF,
                                           input int num  = NUM_QP_DEF);
        qp_map_t m;
        int      off;
        off   = int'(qpn) - base;
        m.vld = (off >= 0) && (off < num);
        m.idx = m.vld ? QPN_W'(off) : '0;
        return m;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr wins.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);
    logic found;

    // k is the distance from ptr; requester i sits at distance k when ptr == (i-k) mod N
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (ptr == PTR_W'((i - k + N) % N))) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/qpn_tx_scheduler.sv
// Per-QP RoCE transmit scheduler: round-robin grant onto the TX builder,
// PSN assignment and an outstanding-packet window closed by cumulative ACKs.
module qpn_tx_scheduler
    import qpn_sched_pkg::*;
#(
    parameter int NUM_QP          = NUM_QP_DEF,
    parameter int QP_BASE         = QP_BASE_DEF,
    parameter int MAX_OUTSTANDING = 8,
    parameter int PSN_W           = PSN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_QP-1:0]    req_valid,
    input  logic [NUM_QP*16-1:0] req_len,
    output logic [NUM_QP-1:0]    req_ready,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [3:0]           tx_qpn,
    output logic [PSN_W-1:0]     tx_psn,
    output logic [15:0]          tx_len,
    input  logic                 ack_valid,
    input  logic [3:0]           ack_qpn,
    input  logic [PSN_W-1:0]     ack_psn,
    output logic                 ack_drop,
    input  logic                 cfg_load,
    input  logic [3:0]           cfg_qpn,
    input  logic [PSN_W-1:0]     cfg_psn,
    output logic [NUM_QP-1:0]    qp_stall
);
    localparam int               IDX_W   = (NUM_QP > 1) ? $clog2(NUM_QP) : 1;
    localparam logic [PSN_W-1:0] MAX_OUT = PSN_W'(MAX_OUTSTANDING);

    sched_state_e                 state_q, state_d;
    logic [IDX_W-1:0]             rr_ptr_q, rr_ptr_d, gnt_idx_q, gnt_idx_d;
    logic [NUM_QP-1:0][PSN_W-1:0] next_psn_q, next_psn_d, una_q, una_d, outstanding;
    logic [NUM_QP-1:0]            eligible, gnt, ack_hit, cfg_hit;
    logic [NUM_QP-1:0]            req_ready_q, req_ready_d, qp_stall_q, qp_stall_d;
    logic                         tx_valid_q, tx_valid_d, ack_drop_q, ack_drop_d;
    logic [3:0]                   tx_qpn_q, tx_qpn_d;
    logic [PSN_W-1:0]             tx_psn_q, tx_psn_d;
    logic [15:0]                  tx_len_q, tx_len_d;
    logic                         hs, ack_ok;
    qp_map_t                      ack_map, cfg_map;

    assign ack_map = qpn_to_idx(ack_qpn, QP_BASE, NUM_QP);
    assign cfg_map = qpn_to_idx(cfg_qpn, QP_BASE, NUM_QP);

    always_comb begin
        outstanding = '0;
        eligible    = '0;
        for (int i = 0; i < NUM_QP; i++) begin
            outstanding[i] = next_psn_q[i] - una_q[i];
            eligible[i]    = req_valid[i] && (outstanding[i] < MAX_OUT);
        end
    end

    rr_arbiter #(.N(NUM_QP), .PTR_W(IDX_W)) u_arb (
        .req (eligible),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        tx_valid_d  = tx_valid_q;
        tx_qpn_d    = tx_qpn_q;
        tx_psn_d    = tx_psn_q;
        tx_len_d    = tx_len_q;
        req_ready_d = '0;
        next_psn_d  = next_psn_q;
        una_d       = una_q;
        ack_hit     = '0;
        cfg_hit     = '0;
        qp_stall_d  = '0;
        ack_ok      = 1'b0;
        hs          = tx_valid_q && tx_ready;

        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d     = ISSUE;
                    tx_valid_d  = 1'b1;
                    req_ready_d = gnt;
                    for (int i = 0; i < NUM_QP; i++) begin
                        if (gnt[i]) begin
                            gnt_idx_d = IDX_W'(i);
                            tx_qpn_d  = 4'(QP_BASE + i);
                            tx_psn_d  = next_psn_q[i];
                            tx_len_d  = req_len[16*i +: 16];
                        end
                    end
                end
            end
            ISSUE: begin
                if (hs) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                    rr_ptr_d   = (gnt_idx_q == IDX_W'(NUM_QP - 1)) ? '0 : gnt_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A start-PSN load overrides both the ACK and the handshake increment on its QP
        for (int i = 0; i < NUM_QP; i++) begin
            ack_hit[i] = ack_valid && ack_map.vld && (ack_map.idx == 4'(i)) &&
                         ((ack_psn - una_q[i]) < outstanding[i]);
            cfg_hit[i] = cfg_load && cfg_map.vld && (cfg_map.idx == 4'(i));
            ack_ok     = ack_ok | ack_hit[i];
            if (cfg_hit[i]) begin
                next_psn_d[i] = cfg_psn;
                una_d[i]      = cfg_psn;
            end else begin
                if (hs && (gnt_idx_q == IDX_W'(i)))
                    next_psn_d[i] = next_psn_q[i] + 1'b1;
                if (ack_hit[i])
                    una_d[i] = ack_psn + 1'b1;
            end
            qp_stall_d[i] = (next_psn_d[i] - una_d[i]) == MAX_OUT;
        end
        ack_drop_d = ack_valid && !ack_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_qpn_q    <= '0;
            tx_psn_q    <= '0;
            tx_len_q    <= '0;
            req_ready_q <= '0;
            ack_drop_q  <= 1'b0;
            qp_stall_q  <= '0;
            next_psn_q  <= '0;
            una_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            tx_valid_q  <= tx_valid_d;
            tx_qpn_q    <= tx_qpn_d;
            tx_psn_q    <= tx_psn_d;
            tx_len_q    <= tx_len_d;
            req_ready_q <= req_ready_d;
            ack_drop_q  <= ack_drop_d;
            qp_stall_q  <= qp_stall_d;
            next_psn_q  <= next_psn_d;
            una_q       <= una_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_qpn    = tx_qpn_q;
    assign tx_psn    = tx_psn_q;
    assign tx_len    = tx_len_q;
    assign ack_drop  = ack_drop_q;
    assign qp_stall  = qp_stall_q;
endmodule

// File: tb/tb_qpn_tx_scheduler.sv
// Bench for qpn_tx_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the scheduler rules.
module tb_qpn_tx_scheduler;
    localparam int NQ   = 3;
    localparam int BASE = 2;
    localparam int MAXO = 8;
    localparam int PW   = 24;
    localparam int MASK = 32'h00FF_FFFF;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NQ-1:0]    req_valid = '0;
    logic [NQ*16-1:0] req_len = '0;
    logic [NQ-1:0]    req_ready;
    logic             tx_valid;
    logic             tx_ready = 1'b0;
    logic [3:0]       tx_qpn;
    logic [PW-1:0]    tx_psn;
    logic [15:0]      tx_len;
    logic             ack_valid = 1'b0;
    logic [3:0]       ack_qpn = '0;
    logic [PW-1:0]    ack_psn = '0;
    logic             ack_drop;
    logic             cfg_load = 1'b0;
    logic [3:0]       cfg_qpn = '0;
    logic [PW-1:0]    cfg_psn = '0;
    logic [NQ-1:0]    qp_stall;

    always #5 clk = ~clk;

    qpn_tx_scheduler #(.NUM_QP(NQ), .QP_BASE(BASE), .MAX_OUTSTANDING(MAXO), .PSN_W(PW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_qpn(tx_qpn), .tx_psn(tx_psn), .tx_len(tx_len),
        .ack_valid(ack_valid), .ack_qpn(ack_qpn), .ack_psn(ack_psn), .ack_drop(ack_drop),
        .cfg_load(cfg_load), .cfg_qpn(cfg_qpn), .cfg_psn(cfg_psn), .qp_stall(qp_stall)
    );

    // model: per-QP PSN counters, one in-flight descriptor, round-robin start
    int m_next[NQ], m_una[NQ];
    bit m_busy;
    int m_g, m_rr;
    logic          e_tx_valid, e_ack_drop;
    int            e_qpn, e_psn, e_len;
    logic [NQ-1:0] e_req_ready, e_stall;

    int checks = 0, failures = 0;
    int cyc = 0, rdy_pulses = 0;
    int lg_qpn[$], lg_psn[$], lg_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        int outst[NQ], nn[NQ], nu[NQ];
        int ai, ci;
        bit found;
        e_req_ready = '0;
        e_ack_drop  = 1'b0;
        if (rst) begin
            for (int i = 0; i < NQ; i++) begin m_next[i] = 0; m_una[i] = 0; end
            m_busy = 0; m_rr = 0; m_g = 0;
            e_tx_valid = 0; e_qpn = 0; e_psn = 0; e_len = 0; e_stall = '0;
            return;
        end
        for (int i = 0; i < NQ; i++) begin
            outst[i] = (m_next[i] - m_una[i]) & MASK;
            nn[i] = m_next[i];
            nu[i] = m_una[i];
        end
        if (!m_busy) begin
            found = 0;
            for (int k = 0; k < NQ; k++) begin
                int j;
                j = (m_rr + k) % NQ;
                if (!found && req_valid[j] && outst[j] < MAXO) begin
                    found = 1; m_busy = 1; m_g = j;
                    e_req_ready[j] = 1'b1;
                    e_qpn = BASE + j;
                    e_psn = m_next[j];
                    e_len = int'(req_len[16*j +: 16]);
                end
            end
        end else if (tx_ready) begin
            m_busy = 0;
            m_rr = (m_g + 1) % NQ;
            nn[m_g] = (m_next[m_g] + 1) & MASK;
        end
        if (ack_valid) begin
            ai = int'(ack_qpn) - BASE;
            if (ai >= 0 && ai < NQ && (((int'(ack_psn) - m_una[ai]) & MASK) < outst[ai]))
                nu[ai] = (int'(ack_psn) + 1) & MASK;
            else
                e_ack_drop = 1'b1;
        end
        if (cfg_load) begin
            ci = int'(cfg_qpn) - BASE;
            if (ci >= 0 && ci < NQ) begin
                nn[ci] = int'(cfg_psn);
                nu[ci] = int'(cfg_psn);
            end
        end
        for (int i = 0; i < NQ; i++) begin
            m_next[i] = nn[i];
            m_una[i]  = nu[i];
            e_stall[i] = (((nn[i] - nu[i]) & MASK) == MAXO);
        end
        e_tx_valid = m_busy;
    endtask

    task automatic compare();
        chk("tx_valid", int'(tx_valid), int'(e_tx_valid));
        chk("tx_qpn", int'(tx_qpn), e_qpn);
        chk("tx_psn", int'(tx_psn), e_psn);
        chk("tx_len", int'(tx_len), e_len);
        chk("req_ready", int'(req_ready), int'(e_req_ready));
        chk("ack_drop", int'(ack_drop), int'(e_ack_drop));
        chk("qp_stall", int'(qp_stall), int'(e_stall));
    endtask

    task automatic cycle();
        if (tx_valid && tx_ready && !rst) begin
            lg_qpn.push_back(int'(tx_qpn));
            lg_psn.push_back(int'(tx_psn));
            lg_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        rdy_pulses += $countones(req_ready);
        compare();
    endtask

    task automatic clear_inputs();
        req_valid = '0; tx_ready = 1'b0;
        ack_valid = 1'b0; cfg_load = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        cycle();
        cycle();
        rst = 1'b0;
        lg_qpn.delete(); lg_psn.delete(); lg_cyc.delete();
        rdy_pulses = 0;
    endtask

    task automatic issue_one(input int qp, input logic [15:0] len);
        int n;
        req_valid[qp] = 1'b1;
        req_len[16*qp +: 16] = len;
        n = 0;
        while (!e_req_ready[qp] && n < 40) begin cycle(); n++; end
        chk("grant_wait", int'(e_req_ready[qp]), 1);
        req_valid[qp] = 1'b0;
        n = 0;
        while (e_tx_valid && n < 40) begin cycle(); n++; end
        chk("handshake_wait", int'(e_tx_valid), 0);
    endtask

    task automatic send_ack(input int qpn, input int psn);
        ack_valid = 1'b1; ack_qpn = 4'(qpn); ack_psn = PW'(psn);
        cycle();
        ack_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // reset state
        do_reset();
        chk("rst_tx_valid", int'(tx_valid), 0);
        chk("rst_tx_psn", int'(tx_psn), 0);
        chk("rst_tx_qpn", int'(tx_qpn), 0);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_qp_stall", int'(qp_stall), 0);

        // all three QPs requesting: QPn 2,3,4,2 with PSN 0,0,0,1 every 2 cycles
        req_valid = 3'b111; req_len = {16'h0300, 16'h0200, 16'h0100}; tx_ready = 1'b1;
        repeat (10) cycle();
        chk("rr_count", (lg_qpn.size() >= 4) ? 1 : 0, 1);
        if (lg_qpn.size() >= 4) begin
            chk("rr_qpn0", lg_qpn[0], 2); chk("rr_psn0", lg_psn[0], 0);
            chk("rr_qpn1", lg_qpn[1], 3); chk("rr_psn1", lg_psn[1], 0);
            chk("rr_qpn2", lg_qpn[2], 4); chk("rr_psn2", lg_psn[2], 0);
            chk("rr_qpn3", lg_qpn[3], 2); chk("rr_psn3", lg_psn[3], 1);
            for (int k = 0; k < 3; k++) chk("rr_spacing", lg_cyc[k+1] - lg_cyc[k], 2);
        end

        // window: QPn 3 alone fills 8 packets then stalls until ACK
        do_reset();
        req_valid = 3'b010; tx_ready = 1'b1;
        repeat (30) cycle();
        chk("win_count", lg_psn.size(), 8);
        for (int k = 0; k < lg_psn.size() && k < 8; k++) chk("win_psn", lg_psn[k], k);
        chk("win_stall", int'(qp_stall), 3'b010);
        send_ack(3, 3);
        chk("win_stall_clear", int'(qp_stall), 0);
        chk("win_ack_ok", int'(ack_drop), 0);
        repeat (4) cycle();
        req_valid = '0;
        repeat (3) cycle();
        chk("win_resume", (lg_psn.size() >= 9) ? 1 : 0, 1);
        if (lg_psn.size() >= 9) chk("win_psn8", lg_psn[8], 8);

        // backpressure: descriptor held, one req_ready pulse
        do_reset();
        req_len[15:0] = 16'h1234; req_valid = 3'b001; tx_ready = 1'b0;
        repeat (6) cycle();
        chk("bp_pulses", rdy_pulses, 1);
        chk("bp_valid", int'(tx_valid), 1);
        chk("bp_len", int'(tx_len), 16'h1234);
        chk("bp_qpn", int'(tx_qpn), 2);
        req_valid = '0; tx_ready = 1'b1;
        repeat (3) cycle();

        // PSN wrap after start-PSN load
        do_reset();
        cfg_load = 1'b1; cfg_qpn = 4'd2; cfg_psn = 24'hFFFFFE;
        cycle();
        cfg_load = 1'b0; tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) issue_one(0, 16'(16 + k));
        chk("wrap_count", lg_psn.size(), 3);
        if (lg_psn.size() == 3) begin
            chk("wrap_psn0", lg_psn[0], 24'hFFFFFE);
            chk("wrap_psn1", lg_psn[1], 24'hFFFFFF);
            chk("wrap_psn2", lg_psn[2], 0);
        end
        send_ack(2, 24'hFFFFFF);
        chk("wrap_ack_ok", int'(ack_drop), 0);
        chk("wrap_outst", (m_next[0] - m_una[0]) & MASK, 1);

        // rejected ACKs: unknown QPn, duplicate, beyond next_psn-1
        send_ack(5, 0);
        chk("drop_qpn", int'(ack_drop), 1);
        cycle();
        chk("drop_pulse_end", int'(ack_drop), 0);
        send_ack(2, 24'hFFFFFF);
        chk("drop_dup", int'(ack_drop), 1);
        send_ack(2, 1);
        chk("drop_ahead", int'(ack_drop), 1);
        chk("drop_una", m_una[0], 0);
        chk("drop_next", m_next[0], 1);
        send_ack(2, 0);
        chk("ack_after_drops", int'(ack_drop), 0);

        // QPn 4: handshake, ACK and start-PSN load in the same cycle
        do_reset();
        tx_ready = 1'b1;
        issue_one(2, 16'h0040);
        req_valid[2] = 1'b1; tx_ready = 1'b0;
        for (int n = 0; n < 40 && !e_req_ready[2]; n++) cycle();
        req_valid[2] = 1'b0;
        chk("same_inflight_psn", int'(tx_psn), 1);
        tx_ready = 1'b1;
        ack_valid = 1'b1; ack_qpn = 4'd4; ack_psn = 24'd0;
        cfg_load = 1'b1; cfg_qpn = 4'd4; cfg_psn = 24'h000100;
        cycle();
        ack_valid = 1'b0; cfg_load = 1'b0;
        chk("same_hs_psn", (lg_psn.size() > 0) ? lg_psn[lg_psn.size()-1] : -1, 1);
        chk("same_ack_ok", int'(ack_drop), 0);
        chk("same_next", m_next[2], 24'h100);
        chk("same_una", m_una[2], 24'h100);
        issue_one(2, 16'h0041);
        chk("same_new_psn", (lg_psn.size() > 0) ? lg_psn[lg_psn.size()-1] : -1, 24'h100);

        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            tx_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NQ; i++) begin
                if (!req_valid[i] || e_req_ready[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_len[16*i +: 16] = 16'($urandom);
                end
            end
            ack_valid = ($urandom_range(0, 9) < 3);
            if (ack_valid) begin
                int q, ix;
                q  = $urandom_range(1, 6);
                ix = (q >= BASE && q < BASE + NQ) ? q - BASE : 0;
                ack_qpn = 4'(q);
                ack_psn = PW'((m_una[ix] + int'($urandom_range(0, MAXO + 2)) - 1) & MASK);
            end
            cfg_load = ($urandom_range(0, 99) == 0);
            if (cfg_load) begin
                cfg_qpn = 4'($urandom_range(1, 5));
                cfg_psn = ($urandom_range(0, 1) == 1) ? PW'(24'hFFFFFC + $urandom_range(0, 3))
                                                       : PW'($urandom);
            end
            cycle();
        end
        rst = 1'b0;
        clear_inputs();
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
